// File: rtl/output_sequencer.sv
// Serializes LANES-wide output-channel groups into a single-element stream in
// (oy, ox, oc) order, trimming the partial last oc group and flagging the layer's final element.
module output_sequencer #(
  parameter int ACC_W = 32,
  parameter int LANES = 8,
  parameter int DIM_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_start,
  input  logic [DIM_W-1:0]       cfg_oh,
  input  logic [DIM_W-1:0]       cfg_ow,
  input  logic [DIM_W-1:0]       cfg_oc,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err,
  input  logic                   grp_valid,
  output logic                   grp_ready,
  input  logic [LANES*ACC_W-1:0] grp_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out_data,
  output logic                   out_last
);

  localparam int LIDX_W = $clog2(LANES);
  localparam logic [DIM_W:0]  LANES_WIDE = (DIM_W+1)'(LANES);
  localparam logic [LIDX_W:0] LANES_CNT  = (LIDX_W+1)'(LANES);
  localparam logic [LIDX_W:0] ONE_CNT    = (LIDX_W+1)'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, EMIT = 2'd2, DONE = 2'd3} state_t;

  state_t                 state_r;
  logic [DIM_W-1:0]       oh_r, ow_r, oc_r;
  logic [DIM_W-1:0]       oy_r, ox_r, oc_base_r;
  logic [LANES*ACC_W-1:0] data_buf_r;
  logic [LIDX_W-1:0]      lane_idx_r;
  logic [LIDX_W:0]        n_lanes_r;

  logic [DIM_W-1:0]       rem_s;
  logic [LIDX_W:0]        n_lanes_s;
  logic                   more_oc_s;
  logic                   last_grp_s;
  logic                   lane_end_s;
  logic [LIDX_W-1:0]      nxt_idx_s;
  logic                   nxt_last_s;
  logic                   load_last_s;

  function automatic logic [ACC_W-1:0] lane_word(input logic [LANES*ACC_W-1:0] vec,
                                                 input logic [LIDX_W-1:0] idx);
    return vec[int'(idx)*ACC_W +: ACC_W];
  endfunction

  // Group bookkeeping; oc_base+LANES is compared one bit wider so it cannot wrap.
  always_comb begin
    rem_s      = oc_r - oc_base_r;
    more_oc_s  = ({1'b0, oc_base_r} + LANES_WIDE) < {1'b0, oc_r};
    last_grp_s = (oy_r == oh_r - DIM_W'(1)) && (ox_r == ow_r - DIM_W'(1)) && !more_oc_s;
    if (rem_s >= DIM_W'(LANES)) begin
      n_lanes_s = LANES_CNT;
    end else begin
      n_lanes_s = rem_s[LIDX_W:0];
    end
    nxt_idx_s   = lane_idx_r + LIDX_W'(1);
    lane_end_s  = ({1'b0, lane_idx_r} == n_lanes_r - ONE_CNT);
    nxt_last_s  = last_grp_s && ({1'b0, nxt_idx_s} == n_lanes_r - ONE_CNT);
    load_last_s = last_grp_s && (n_lanes_s == ONE_CNT);
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      oh_r       <= {DIM_W{1'b0}};
      ow_r       <= {DIM_W{1'b0}};
      oc_r       <= {DIM_W{1'b0}};
      oy_r       <= {DIM_W{1'b0}};
      ox_r       <= {DIM_W{1'b0}};
      oc_base_r  <= {DIM_W{1'b0}};
      data_buf_r <= {(LANES*ACC_W){1'b0}};
      lane_idx_r <= {LIDX_W{1'b0}};
      n_lanes_r  <= {(LIDX_W+1){1'b0}};
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
      grp_ready  <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= {ACC_W{1'b0}};
      out_last   <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cfg_start) begin
            if ((cfg_oh == {DIM_W{1'b0}}) || (cfg_ow == {DIM_W{1'b0}}) || (cfg_oc == {DIM_W{1'b0}})) begin
              cfg_err <= 1'b1;
            end else begin
              oh_r      <= cfg_oh;
              ow_r      <= cfg_ow;
              oc_r      <= cfg_oc;
              oy_r      <= {DIM_W{1'b0}};
              ox_r      <= {DIM_W{1'b0}};
              oc_base_r <= {DIM_W{1'b0}};
              busy      <= 1'b1;
              grp_ready <= 1'b1;
              state_r   <= LOAD;
            end
          end
        end
        LOAD: begin
          if (grp_valid) begin
            data_buf_r <= grp_data;
            lane_idx_r <= {LIDX_W{1'b0}};
            n_lanes_r  <= n_lanes_s;
            grp_ready  <= 1'b0;
            out_valid  <= 1'b1;
            out_data   <= grp_data[ACC_W-1:0];
            out_last   <= load_last_s;
            state_r    <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (lane_end_s) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= {ACC_W{1'b0}};
              if (more_oc_s) begin
                oc_base_r <= oc_base_r + DIM_W'(LANES);
              end else if (ox_r < ow_r - DIM_W'(1)) begin
                oc_base_r <= {DIM_W{1'b0}};
                ox_r      <= ox_r + DIM_W'(1);
              end else if (oy_r < oh_r - DIM_W'(1)) begin
                oc_base_r <= {DIM_W{1'b0}};
                ox_r      <= {DIM_W{1'b0}};
                oy_r      <= oy_r + DIM_W'(1);
              end else begin
                oc_base_r <= oc_base_r;
              end
              if (last_grp_s) begin
                done    <= 1'b1;
                state_r <= DONE;
              end else begin
                grp_ready <= 1'b1;
                state_r   <= LOAD;
              end
            end else begin
              lane_idx_r <= nxt_idx_s;
              out_data   <= lane_word(data_buf_r, nxt_idx_s);
              out_last   <= nxt_last_s;
            end
          end
        end
        DONE: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_sequencer.sv
// Randomized bench for output_sequencer: a queue-based reference model expands each layer
// into its expected element stream and checks order, trimming, out_last and control timing.
module tb_output_sequencer;

  localparam int ACC_W = 32;
  localparam int LANES = 8;
  localparam int DIM_W = 16;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   cfg_start;
  logic [DIM_W-1:0]       cfg_oh, cfg_ow, cfg_oc;
  logic                   busy, done, cfg_err;
  logic                   grp_valid, grp_ready;
  logic [LANES*ACC_W-1:0] grp_data;
  logic                   out_valid, out_ready;
  logic [ACC_W-1:0]       out_data;
  logic                   out_last;

  always #5 clk = ~clk;

  output_sequencer #(.ACC_W(ACC_W), .LANES(LANES), .DIM_W(DIM_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start),
    .cfg_oh(cfg_oh), .cfg_ow(cfg_ow), .cfg_oc(cfg_oc),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .grp_valid(grp_valid), .grp_ready(grp_ready), .grp_data(grp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  int tests = 0;
  int fails = 0;
  logic [ACC_W-1:0]       exp_data_q[$];
  bit                     exp_last_q[$];
  logic [LANES*ACC_W-1:0] grp_q[$];
  int grp_ready_cnt, grp_acc_cnt, first_acc, last_acc, n_acc;

  // Expand a layer into groups to feed and the exact element stream expected back.
  task automatic build_model(input int oh, input int ow, input int oc, input int dmode);
    exp_data_q.delete(); exp_last_q.delete(); grp_q.delete();
    for (int y = 0; y < oh; y++)
      for (int x = 0; x < ow; x++)
        for (int base = 0; base < oc; base += LANES) begin
          logic [LANES*ACC_W-1:0] g;
          int n;
          for (int i = 0; i < LANES; i++) begin
            logic [ACC_W-1:0] v;
            int r;
            r = int'($urandom_range(0, 7));
            case (dmode)
              0: v = ACC_W'(i + 1);
              1: v = ACC_W'(100 + i);
              2: v = (r == 0) ? 32'hFFFF_FFFF : (r == 1) ? 32'h8000_0000 : $urandom;
              default: v = 32'hFFFF_FFFF;
            endcase
            g[i*ACC_W +: ACC_W] = v;
          end
          grp_q.push_back(g);
          n = (oc - base < LANES) ? oc - base : LANES;
          for (int i = 0; i < n; i++) begin
            exp_data_q.push_back(g[i*ACC_W +: ACC_W]);
            exp_last_q.push_back(y == oh-1 && x == ow-1 && base + LANES >= oc && i == n-1);
          end
        end
  endtask

  task automatic run_layer(input int oh, input int ow, input int oc, input int rmode,
                           input int dmode, input bit noise, input string tag);
    int cyc;
    bit fin, prev_stall, prev_gacc;
    logic [ACC_W-1:0] prev_data, ed;
    logic prev_last, el;
    build_model(oh, ow, oc, dmode);
    grp_ready_cnt = 0; grp_acc_cnt = 0; first_acc = -1; last_acc = -1; n_acc = 0;
    @(negedge clk);
    cfg_oh = DIM_W'(oh); cfg_ow = DIM_W'(ow); cfg_oc = DIM_W'(oc); cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    tests++;
    if (busy !== 1'b1 || grp_ready !== 1'b1) begin
      fails++; $display("FAIL %s start: busy=%b grp_ready=%b, expected 1 1", tag, busy, grp_ready);
    end
    cyc = 0; fin = 0; prev_stall = 0; prev_gacc = 0; prev_data = '0; prev_last = 0;
    while (!fin && cyc < 5000) begin
      tests++;
      if (cfg_err !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
        fails++; $display("FAIL %s ctrl: cfg_err=%b done=%b busy=%b, expected 0 0 1", tag, cfg_err, done, busy);
      end
      if (prev_stall) begin
        tests++;
        if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
          fails++; $display("FAIL %s stall: valid=%b data=%h last=%b, expected 1 %h %b",
                            tag, out_valid, out_data, out_last, prev_data, prev_last);
        end
      end
      if (prev_gacc) begin
        tests++;
        if (out_valid !== 1'b1) begin
          fails++; $display("FAIL %s latency: out_valid=%b after group, expected 1", tag, out_valid);
        end
      end
      if (grp_ready === 1'b1) begin
        grp_ready_cnt++;
        tests++;
        if (out_valid !== 1'b0) begin
          fails++; $display("FAIL %s overlap: out_valid=%b with grp_ready, expected 0", tag, out_valid);
        end
      end
      out_ready = (rmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      grp_valid = (grp_ready === 1'b1) && (grp_q.size() > 0) && (rmode == 0 || $urandom_range(0, 3) != 0);
      if (grp_q.size() > 0) grp_data = grp_q[0];
      cfg_start = noise && (out_valid === 1'b1);
      if (noise) cfg_oc = '0;
      prev_gacc = grp_valid && (grp_ready === 1'b1);
      if (prev_gacc) begin
        void'(grp_q.pop_front());
        grp_acc_cnt++;
      end
      if (out_valid === 1'b1 && out_ready) begin
        tests++;
        if (exp_data_q.size() == 0) begin
          fails++; $display("FAIL %s extra: data=%h emitted, expected no more elements", tag, out_data);
        end else begin
          ed = exp_data_q.pop_front();
          el = exp_last_q.pop_front();
          if (out_data !== ed || out_last !== el) begin
            fails++; $display("FAIL %s elem %0d: data=%h last=%b, expected %h %b",
                              tag, n_acc, out_data, out_last, ed, el);
          end
        end
        n_acc++;
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        if (exp_data_q.size() == 0) fin = 1;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
      @(negedge clk);
      cyc++;
    end
    grp_valid = 1'b0;
    tests++;
    if (!fin) begin
      fails++; $display("FAIL %s timeout: %0d elements left after %0d cycles, expected 0", tag, exp_data_q.size(), cyc);
    end
    tests++;
    if (n_acc != oh*ow*oc) begin
      fails++; $display("FAIL %s count: %0d elements, expected %0d", tag, n_acc, oh*ow*oc);
    end
    tests++;
    if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0 || grp_ready !== 1'b0) begin
      fails++; $display("FAIL %s done: done=%b busy=%b valid=%b rdy=%b, expected 1 1 0 0",
                        tag, done, busy, out_valid, grp_ready);
    end
    @(negedge clk);
    cfg_start = 1'b0;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || cfg_err !== 1'b0) begin
      fails++; $display("FAIL %s idle: done=%b busy=%b cfg_err=%b, expected 0 0 0", tag, done, busy, cfg_err);
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || cfg_err !== 1'b0 || grp_ready !== 1'b0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL %s post: busy=%b cfg_err=%b rdy=%b valid=%b, expected 0 0 0 0",
                        tag, busy, cfg_err, grp_ready, out_valid);
    end
  endtask

  task automatic check_all_zero(input string tag);
    tests++;
    if ({busy, done, cfg_err, grp_ready, out_valid, out_last} !== 6'b0 || out_data !== '0) begin
      fails++; $display("FAIL %s: busy=%b done=%b err=%b rdy=%b valid=%b last=%b data=%h, expected all 0",
                        tag, busy, done, cfg_err, grp_ready, out_valid, out_last, out_data);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_start = 1'b0; cfg_oh = '0; cfg_ow = '0; cfg_oc = '0;
    grp_valid = 1'b0; grp_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_hold");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("reset_release");
  endtask

  task automatic test_single_group();
    run_layer(1, 1, 8, 0, 0, 0, "single");
    tests++;
    if (grp_ready_cnt != 1 || last_acc - first_acc != 7) begin
      fails++; $display("FAIL single_timing: grp_ready cycles=%0d beat span=%0d, expected 1 7",
                        grp_ready_cnt, last_acc - first_acc);
    end
  endtask

  task automatic test_partial_group();
    run_layer(1, 2, 10, 0, 1, 0, "partial");
    tests++;
    if (grp_acc_cnt != 4) begin
      fails++; $display("FAIL partial_groups: %0d groups accepted, expected 4", grp_acc_cnt);
    end
  endtask

  task automatic test_random_ready();
    run_layer(2, 2, 8, 1, 2, 0, "random_ready");
  endtask

  task automatic test_zero_dim();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      cfg_oh = (k == 0) ? 16'd1 : 16'd0; cfg_ow = 16'd1; cfg_oc = (k == 0) ? 16'd0 : 16'd4;
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      tests++;
      if (cfg_err !== 1'b1 || busy !== 1'b0 || grp_ready !== 1'b0 || out_valid !== 1'b0) begin
        fails++; $display("FAIL zero_dim%0d: err=%b busy=%b rdy=%b valid=%b, expected 1 0 0 0",
                          k, cfg_err, busy, grp_ready, out_valid);
      end
      repeat (3) begin
        @(negedge clk);
        check_all_zero("zero_dim_after");
      end
    end
    run_layer(1, 1, 8, 0, 2, 0, "after_zero");
  endtask

  task automatic test_sign_and_noise();
    run_layer(1, 1, 3, 1, 3, 1, "sign_noise");
    run_layer(1, 2, 12, 1, 2, 1, "noise2");
  endtask

  task automatic test_reset_mid_emit();
    build_model(1, 1, 8, 2);
    @(negedge clk);
    cfg_oh = 16'd1; cfg_ow = 16'd1; cfg_oc = 16'd8; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0; grp_valid = 1'b1; grp_data = grp_q[0]; out_ready = 1'b0;
    @(negedge clk);
    grp_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_data !== exp_data_q[1]) begin
      fails++; $display("FAIL rst_pre: valid=%b data=%h, expected 1 %h", out_valid, out_data, exp_data_q[1]);
    end
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_mid_emit");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_all_zero("rst_after");
    end
    run_layer(2, 3, 5, 1, 2, 0, "after_reset");
  endtask

  task automatic test_back_to_back();
    run_layer(1, 1, 1, 0, 2, 0, "oc_one");
    run_layer(3, 1, 17, 1, 2, 0, "oc_17");
    run_layer(1, 3, 16, 0, 2, 0, "oc_16");
  endtask

  initial begin
    test_reset();
    test_single_group();
    test_partial_group();
    test_random_ready();
    test_zero_dim();
    test_sign_and_noise();
    test_reset_mid_emit();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
